// File: rtl/instr_pkg.sv
// Shared widths, memory-word field positions, fetch FSM states and the IF/ID
// register layout for the instruction-fetch stage.
package instr_pkg;

  localparam int ADDR_W   = 8;
  localparam int OPCODE_W = 3;
  localparam int AUX_W    = 3;
  localparam int PERF_W   = 16;

  localparam int OPCODE_LSB = 0;
  localparam int RT_BIT     = 3;
  localparam int RS_BIT     = 4;
  localparam int AUX_LSB    = 5;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic                valid;
    logic [ADDR_W-1:0]   pc;
    logic [OPCODE_W-1:0] opcode;
    logic                rt;
    logic                rs;
    logic [AUX_W-1:0]    aux;
  } if_id_t;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating event counter used by the optional fetch performance monitors.
module fetch_perf_ctr
  import instr_pkg::*;
(
  input  logic              sysclk,
  input  logic              reset,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {PERF_W{1'b1}})) begin
      count <= count + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, drives instruction-memory address, registers decoded fields.
// Optional counters enabled by defining INSTR_FETCH_PERF_EN.
module instr_fetch
  import instr_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter bit                WRAP     = 1'b1
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_addr,
  input  logic                halt,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [OPCODE_W-1:0] mem_opcode,
  input  logic                mem_rt,
  input  logic                mem_rs,
  input  logic [AUX_W-1:0]    mem_aux,
  output logic                if_id_valid,
  output logic [ADDR_W-1:0]   if_id_pc,
  output logic [OPCODE_W-1:0] if_id_opcode,
  output logic                if_id_rt,
  output logic                if_id_rs,
  output logic [AUX_W-1:0]    if_id_aux,
  output logic                halted,
`ifdef INSTR_FETCH_PERF_EN
  output logic [PERF_W-1:0]   perf_fetched,
  output logic [PERF_W-1:0]   perf_stalled,
`endif
  output logic [1:0]          dbg_state
);

  // Handshake: if_id_valid is the offer to ID, stall is ID's "not ready".
  // A held instruction is only retired on an edge where stall is low.
  fetch_state_e        state;
  logic [ADDR_W-1:0]   pc;
  if_id_t              if_id;
  logic                fetch_now;
  logic                stall_now;

  assign fetch_now = (state == RUN) && !redirect_valid && !halt && !stall;
  assign stall_now = (state == RUN) && !redirect_valid && stall;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
      if_id <= '0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redirect_valid) begin
            // Flush beats stall, halt and the non-wrapping end of memory.
            pc    <= redirect_addr;
            if_id <= '0;
          end else if (halt) begin
            state <= HALTED;
            if (!stall) if_id.valid <= 1'b0;
          end else if (!stall) begin
            if_id.valid  <= 1'b1;
            if_id.pc     <= pc;
            if_id.opcode <= mem_opcode;
            if_id.rt     <= mem_rt;
            if_id.rs     <= mem_rs;
            if_id.aux    <= mem_aux;
            if (!WRAP && (pc == {ADDR_W{1'b1}})) begin
              state <= HALTED;
            end else begin
              pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        HALTED: begin
          if (!stall) if_id.valid <= 1'b0;
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign mem_addr     = pc;
  assign if_id_valid  = if_id.valid;
  assign if_id_pc     = if_id.pc;
  assign if_id_opcode = if_id.opcode;
  assign if_id_rt     = if_id.rt;
  assign if_id_rs     = if_id.rs;
  assign if_id_aux    = if_id.aux;
  assign halted       = (state == HALTED);
  assign dbg_state    = state;

`ifdef INSTR_FETCH_PERF_EN
  fetch_perf_ctr u_fetched_ctr (
    .sysclk (sysclk),
    .reset  (reset),
    .inc    (fetch_now),
    .count  (perf_fetched)
  );

  fetch_perf_ctr u_stalled_ctr (
    .sysclk (sysclk),
    .reset  (reset),
    .inc    (stall_now),
    .count  (perf_stalled)
  );
`else
  logic unused_perf;
  assign unused_perf = fetch_now ^ stall_now;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one wrapping and one non-wrapping instance
// share stimulus and a combinational instruction-memory model.
module tb_instr_fetch;

  logic       sysclk;
  logic       reset;
  logic       stall;
  logic       redirect_valid;
  logic [7:0] redirect_addr;
  logic       halt;

  logic [7:0] mem_addr,     mem_addr_nw;
  logic [7:0] word,         word_nw;
  logic       if_id_valid,  if_id_valid_nw;
  logic [7:0] if_id_pc,     if_id_pc_nw;
  logic [2:0] if_id_opcode, if_id_opcode_nw;
  logic       if_id_rt,     if_id_rt_nw;
  logic       if_id_rs,     if_id_rs_nw;
  logic [2:0] if_id_aux,    if_id_aux_nw;
  logic       halted,       halted_nw;
  logic [1:0] dbg_state,    dbg_state_nw;
`ifdef INSTR_FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_stalled, perf_fetched_nw, perf_stalled_nw;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [7:0] mem_word(input logic [7:0] a);
    case (a)
      8'h00:   return 8'b101_1_0_011;
      8'h01:   return 8'b000_0_1_110;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  assign word    = mem_word(mem_addr);
  assign word_nw = mem_word(mem_addr_nw);

  instr_fetch #(.RESET_PC(8'h00), .WRAP(1'b1)) dut (
    .sysclk(sysclk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
    .mem_addr(mem_addr), .mem_opcode(word[2:0]), .mem_rt(word[3]),
    .mem_rs(word[4]), .mem_aux(word[7:5]),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_opcode(if_id_opcode),
    .if_id_rt(if_id_rt), .if_id_rs(if_id_rs), .if_id_aux(if_id_aux),
    .halted(halted),
`ifdef INSTR_FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_stalled(perf_stalled),
`endif
    .dbg_state(dbg_state)
  );

  instr_fetch #(.RESET_PC(8'h00), .WRAP(1'b0)) dut_nw (
    .sysclk(sysclk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
    .mem_addr(mem_addr_nw), .mem_opcode(word_nw[2:0]), .mem_rt(word_nw[3]),
    .mem_rs(word_nw[4]), .mem_aux(word_nw[7:5]),
    .if_id_valid(if_id_valid_nw), .if_id_pc(if_id_pc_nw), .if_id_opcode(if_id_opcode_nw),
    .if_id_rt(if_id_rt_nw), .if_id_rs(if_id_rs_nw), .if_id_aux(if_id_aux_nw),
    .halted(halted_nw),
`ifdef INSTR_FETCH_PERF_EN
    .perf_fetched(perf_fetched_nw), .perf_stalled(perf_stalled_nw),
`endif
    .dbg_state(dbg_state_nw)
  );

  // clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_fields(input string tag, input logic [7:0] a);
    logic [7:0] w;
    w = mem_word(a);
    check({tag, ".valid"},  32'(if_id_valid),  32'd1);
    check({tag, ".pc"},     32'(if_id_pc),     32'(a));
    check({tag, ".opcode"}, 32'(if_id_opcode), 32'(w[2:0]));
    check({tag, ".rt"},     32'(if_id_rt),     32'(w[3]));
    check({tag, ".rs"},     32'(if_id_rs),     32'(w[4]));
    check({tag, ".aux"},    32'(if_id_aux),    32'(w[7:5]));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00; halt = 1'b0;
    #1;
    check("rst.mem_addr", 32'(mem_addr), 32'h00);
    check("rst.valid",    32'(if_id_valid), 32'd0);
    check("rst.halted",   32'(halted), 32'd0);
    check("rst.state",    32'(dbg_state), 32'd0);
    step(); step();
    reset = 1'b0;

    // 1: boot then first two fetches with explicit field values
    step();
    check("boot.valid", 32'(if_id_valid), 32'd0);
    check("boot.mem_addr", 32'(mem_addr), 32'h00);
    check("boot.state", 32'(dbg_state), 32'd1);
    step();
    check("f0.pc", 32'(if_id_pc), 32'h00);
    check("f0.opcode", 32'(if_id_opcode), 32'd3);
    check("f0.rt", 32'(if_id_rt), 32'd0);
    check("f0.rs", 32'(if_id_rs), 32'd1);
    check("f0.aux", 32'(if_id_aux), 32'd5);
    check("f0.valid", 32'(if_id_valid), 32'd1);
    check("f0.mem_addr", 32'(mem_addr), 32'h01);
    step();
    check("f1.opcode", 32'(if_id_opcode), 32'd6);
    check("f1.rt", 32'(if_id_rt), 32'd1);
    check("f1.rs", 32'(if_id_rs), 32'd0);
    check("f1.aux", 32'(if_id_aux), 32'd0);
    check("f1.mem_addr", 32'(mem_addr), 32'h02);
    step(); step(); step();
    check("pre_stall.mem_addr", 32'(mem_addr), 32'h05);

    // 2: stall holds PC and IF/ID
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.mem_addr", 32'(mem_addr), 32'h05);
      check_fields("stall.hold", 8'h04);
    end
    stall = 1'b0;
    step();
    check_fields("unstall", 8'h05);
    check("unstall.mem_addr", 32'(mem_addr), 32'h06);

    // 3: redirect wins over stall
    redirect_valid = 1'b1; redirect_addr = 8'h40; stall = 1'b1;
    step();
    check("redir.valid", 32'(if_id_valid), 32'd0);
    check("redir.mem_addr", 32'(mem_addr), 32'h40);
    check("redir.pc_flushed", 32'(if_id_pc), 32'h00);
    redirect_valid = 1'b0; stall = 1'b0;
    step();
    check_fields("redir.fetch", 8'h40);

    // 4: end of address space, wrapping and non-wrapping
    redirect_valid = 1'b1; redirect_addr = 8'hFE;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap.fe.mem_addr", 32'(mem_addr), 32'hFF);
    check("nw.fe.mem_addr", 32'(mem_addr_nw), 32'hFF);
    redirect_valid = 1'b1; redirect_addr = 8'h10;
    step();
    check("nw.redir_at_ff.mem_addr", 32'(mem_addr_nw), 32'h10);
    check("nw.redir_at_ff.halted", 32'(halted_nw), 32'd0);
    redirect_addr = 8'hFF;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap.mem_addr", 32'(mem_addr), 32'h00);
    check_fields("wrap.ff", 8'hFF);
    check("nw.mem_addr", 32'(mem_addr_nw), 32'hFF);
    check("nw.pc", 32'(if_id_pc_nw), 32'hFF);
    check("nw.valid", 32'(if_id_valid_nw), 32'd1);
    check("nw.opcode", 32'(if_id_opcode_nw), 32'd5);
    check("nw.halted", 32'(halted_nw), 32'd1);
    stall = 1'b1;
    step();
    check("nw.stall.valid", 32'(if_id_valid_nw), 32'd1);
    stall = 1'b0;
    step();
    check("nw.drain.valid", 32'(if_id_valid_nw), 32'd0);
    check("wrap.f00.pc", 32'(if_id_pc), 32'h00);
    redirect_valid = 1'b1; redirect_addr = 8'h20;
    step();
    check("nw.redir_ignored", 32'(mem_addr_nw), 32'hFF);
    check("nw.still_halted", 32'(halted_nw), 32'd1);
    check("wrap.redir.mem_addr", 32'(mem_addr), 32'h20);
    redirect_valid = 1'b0;
    step();
    check_fields("pre_halt", 8'h20);

    // halt with a pending instruction, then drain
    halt = 1'b1; stall = 1'b1;
    step();
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.hold_valid", 32'(if_id_valid), 32'd1);
    check("halt.mem_addr", 32'(mem_addr), 32'h21);
    stall = 1'b0;
    step();
    check("halt.drain", 32'(if_id_valid), 32'd0);
    check("halt.frozen", 32'(mem_addr), 32'h21);
    halt = 1'b0;

    // 5: asynchronous reset between edges, mid-stall and mid-redirect
    #2 reset = 1'b1;
    #1;
    check("areset1.halted", 32'(halted), 32'd0);
    check("areset1.mem_addr", 32'(mem_addr), 32'h00);
    check("areset1.nw_halted", 32'(halted_nw), 32'd0);
    step();
    reset = 1'b0;
    step();
    step();
    step();
    check_fields("rerun.f1", 8'h01);
    stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'h77;
    #2 reset = 1'b1;
    #1;
    check("areset2.valid", 32'(if_id_valid), 32'd0);
    check("areset2.pc", 32'(if_id_pc), 32'h00);
    check("areset2.opcode", 32'(if_id_opcode), 32'd0);
    check("areset2.mem_addr", 32'(mem_addr), 32'h00);
    check("areset2.state", 32'(dbg_state), 32'd0);
    step();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    step();
    check("reboot.valid", 32'(if_id_valid), 32'd0);
    step();
    check_fields("reboot.f0", 8'h00);

`ifdef INSTR_FETCH_PERF_EN
    // 6: performance counters
    reset = 1'b1;
    step();
    check("perf.rst_fetched", 32'(perf_fetched), 32'd0);
    check("perf.rst_stalled", 32'(perf_stalled), 32'd0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 10; i++) step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    stall = 1'b0;
    check("perf.fetched", 32'(perf_fetched), 32'd10);
    check("perf.stalled", 32'(perf_stalled), 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
